// File: rtl/hex_scan_controller.sv
// Four-digit multiplexed 7-segment scan controller with blanking gap, frame-atomic
// data update, leading-zero suppression and whole-display blink.
module hex_scan_controller #(
    parameter int unsigned SCAN_T  = 4,
    parameter int unsigned BLANK_T = 1,
    parameter int unsigned BLINK_T = 500
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic        i_load,
    input  logic [15:0] i_data,
    input  logic [3:0]  i_dp,
    input  logic        i_blink,
    input  logic        i_lz_sup,
    output logic [3:0]  o_hex_en,
    output logic [7:0]  o_hex_seg,
    output logic [1:0]  o_digit_idx
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    localparam int unsigned TMAX = (SCAN_T > BLANK_T) ? SCAN_T : BLANK_T;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int unsigned BW   = (BLINK_T > 1) ? $clog2(BLINK_T) : 1;

    localparam logic [TW-1:0] SCAN_LAST  = TW'(SCAN_T - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_T - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_T - 1);

    logic [1:0]    r_state, w_state_d;
    logic [TW-1:0] r_tcnt, w_tcnt_d;
    logic [1:0]    r_idx, w_idx_d;
    logic [15:0]   r_sh_data, r_act_data, w_act_data_d;
    logic [3:0]    r_sh_dp, r_act_dp, w_act_dp_d;
    logic          r_pending, w_pending_d;
    logic [BW-1:0] r_bcnt, w_bcnt_d;
    logic          r_phase_off, w_phase_off_d;
    logic          w_frame_end, w_copy;
    logic [3:0]    w_nib;
    logic [6:0]    w_dec;
    logic          w_sup, w_lit;
    logic [3:0]    w_hex_en_d;
    logic [7:0]    w_hex_seg_d;

    always_comb begin
        w_state_d   = r_state;
        w_tcnt_d    = r_tcnt;
        w_idx_d     = r_idx;
        w_frame_end = 1'b0;
        if (!i_en) begin
            w_state_d = ST_IDLE;
            w_tcnt_d  = '0;
            w_idx_d   = 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_d = ST_BLANK;
                    w_tcnt_d  = '0;
                end
                ST_BLANK: begin
                    if (r_tcnt == BLANK_LAST) begin
                        w_state_d = ST_DRIVE;
                        w_tcnt_d  = '0;
                    end else begin
                        w_tcnt_d = r_tcnt + 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (r_tcnt == SCAN_LAST) begin
                        w_state_d   = ST_BLANK;
                        w_tcnt_d    = '0;
                        w_idx_d     = r_idx + 2'd1;
                        w_frame_end = (r_idx == 2'd3);
                    end else begin
                        w_tcnt_d = r_tcnt + 1'b1;
                    end
                end
                default: w_state_d = ST_IDLE;
            endcase
        end
    end

    // A load landing on the copy edge bypasses the shadow so it is never lost.
    always_comb begin
        w_copy       = i_en && ((r_state == ST_IDLE) || w_frame_end);
        w_act_data_d = r_act_data;
        w_act_dp_d   = r_act_dp;
        w_pending_d  = r_pending;
        if (w_copy) begin
            w_pending_d = 1'b0;
            if (i_load) begin
                w_act_data_d = i_data;
                w_act_dp_d   = i_dp;
            end else if (r_pending) begin
                w_act_data_d = r_sh_data;
                w_act_dp_d   = r_sh_dp;
            end
        end else if (i_load) begin
            w_pending_d = 1'b1;
        end
    end

    always_comb begin
        w_bcnt_d      = r_bcnt;
        w_phase_off_d = r_phase_off;
        if (!i_en) begin
            w_bcnt_d      = '0;
            w_phase_off_d = 1'b0;
        end else if (r_bcnt == BLINK_LAST) begin
            w_bcnt_d      = '0;
            w_phase_off_d = ~r_phase_off;
        end else begin
            w_bcnt_d = r_bcnt + 1'b1;
        end
    end

    // Outputs are computed from next-state values so they register in step with the FSM.
    always_comb begin
        w_nib = w_act_data_d[{w_idx_d, 2'b00} +: 4];
        case (w_idx_d)
            2'd3:    w_sup = i_lz_sup && (w_act_data_d[15:12] == 4'd0);
            2'd2:    w_sup = i_lz_sup && (w_act_data_d[15:8] == 8'd0);
            2'd1:    w_sup = i_lz_sup && (w_act_data_d[15:4] == 12'd0);
            default: w_sup = 1'b0;
        endcase
        case (w_nib)
            4'd0:    w_dec = 7'h3F;
            4'd1:    w_dec = 7'h06;
            4'd2:    w_dec = 7'h5B;
            4'd3:    w_dec = 7'h4F;
            4'd4:    w_dec = 7'h66;
            4'd5:    w_dec = 7'h6D;
            4'd6:    w_dec = 7'h7D;
            4'd7:    w_dec = 7'h07;
            4'd8:    w_dec = 7'h7F;
            4'd9:    w_dec = 7'h6F;
            default: w_dec = 7'h40;
        endcase
        w_lit       = (w_state_d == ST_DRIVE) && !w_sup;
        w_hex_en_d  = w_lit ? (4'b0001 << w_idx_d) : 4'b0000;
        w_hex_seg_d = (w_lit && !(i_blink && w_phase_off_d)) ?
                      {w_act_dp_d[w_idx_d], w_dec} : 8'h00;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_tcnt      <= '0;
            r_idx       <= 2'd0;
            r_sh_data   <= 16'h0000;
            r_sh_dp     <= 4'h0;
            r_act_data  <= 16'h0000;
            r_act_dp    <= 4'h0;
            r_pending   <= 1'b0;
            r_bcnt      <= '0;
            r_phase_off <= 1'b0;
            o_hex_en    <= 4'h0;
            o_hex_seg   <= 8'h00;
        end else begin
            r_state     <= w_state_d;
            r_tcnt      <= w_tcnt_d;
            r_idx       <= w_idx_d;
            if (i_load) begin
                r_sh_data <= i_data;
                r_sh_dp   <= i_dp;
            end
            r_act_data  <= w_act_data_d;
            r_act_dp    <= w_act_dp_d;
            r_pending   <= w_pending_d;
            r_bcnt      <= w_bcnt_d;
            r_phase_off <= w_phase_off_d;
            o_hex_en    <= w_hex_en_d;
            o_hex_seg   <= w_hex_seg_d;
        end
    end

    assign o_digit_idx = r_idx;

endmodule
